// File: rtl/alu_operand_stage_if.sv
// ALU operand stage bus: upstream decode entry and downstream execute operands.
// Latency: n/a (wires only). Backpressure: valid/ready in each direction.
interface alu_operand_stage_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic            ready_o;
    logic [31:0]     instr_i;
    logic [1:0]      alu_a_src_i;
    logic [1:0]      alu_b_src_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] pc_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] op_a_o;
    logic [XLEN-1:0] op_b_o;
    logic [XLEN-1:0] store_data_o;

    modport slave (
        input  valid_i, instr_i, alu_a_src_i, alu_b_src_i,
        input  rs1_data_i, rs2_data_i, pc_i, ready_i,
        output ready_o, valid_o, op_a_o, op_b_o, store_data_o
    );

    modport master (
        output valid_i, instr_i, alu_a_src_i, alu_b_src_i,
        output rs1_data_i, rs2_data_i, pc_i, ready_i,
        input  ready_o, valid_o, op_a_o, op_b_o, store_data_o
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Immediate extraction + A/B operand select, registered into execute via a 2-entry skid.
// Latency: 1 cycle when empty. Backpressure: ready_o registered, drops once skid fills.
module alu_operand_stage #(
    parameter int XLEN = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    alu_operand_stage_if.slave   bus
);
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] sd;
    } ops_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e          state_q, state_d;
    ops_t            main_q, main_d, skid_q, skid_d, in_ops;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] imm_u, imm_j, imm_b, imm_i, imm_s;
    logic            in_fire, out_fire;
    logic            unused_opcode;

    assign unused_opcode = ^bus.instr_i[6:0];

    // Size casts of signed values replicate instr[31] up to XLEN.
    assign imm_u = XLEN'($signed({bus.instr_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({bus.instr_i[31], bus.instr_i[19:12], bus.instr_i[20],
                                  bus.instr_i[30:21], 1'b0}));
    assign imm_b = XLEN'($signed({bus.instr_i[31], bus.instr_i[7], bus.instr_i[30:25],
                                  bus.instr_i[11:8], 1'b0}));
    assign imm_i = XLEN'($signed(bus.instr_i[31:20]));
    assign imm_s = XLEN'($signed({bus.instr_i[31:25], bus.instr_i[11:7]}));

    always_comb begin
        in_ops    = '0;
        in_ops.sd = bus.rs2_data_i;
        unique case (bus.alu_a_src_i)
            2'b00:   in_ops.a = bus.rs1_data_i;
            2'b01:   in_ops.a = imm_u;
            2'b10:   in_ops.a = imm_j;
            default: in_ops.a = imm_b;
        endcase
        unique case (bus.alu_b_src_i)
            2'b00:   in_ops.b = bus.rs2_data_i;
            2'b01:   in_ops.b = bus.pc_i;
            2'b10:   in_ops.b = imm_i;
            default: in_ops.b = imm_s;
        endcase
    end

    assign in_fire  = bus.valid_i & ready_q;
    assign out_fire = (state_q != EMPTY) & bus.ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_ops;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_ops;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_ops;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.valid_o      = (state_q != EMPTY);
    assign bus.op_a_o       = main_q.a;
    assign bus.op_b_o       = main_q.b;
    assign bus.store_data_o = main_q.sd;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected operands queued on input fire, checked on output fire.
module tb_alu_operand_stage;
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sd;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    int   compares = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t pend;
    logic last_in_fire;

    alu_operand_stage_if #(.XLEN(64)) bus();

    alu_operand_stage #(.XLEN(64)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] sx(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    function automatic exp_t model(input logic [1:0] as, input logic [1:0] bs, input logic [31:0] ins,
                                   input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] pc);
        exp_t e;
        case (as)
            2'd0: e.a = rs1;
            2'd1: e.a = sx({32'h0, ins[31:12], 12'h000}, 32);
            2'd2: e.a = sx({43'h0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            default: e.a = sx({51'h0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        endcase
        case (bs)
            2'd0: e.b = rs2;
            2'd1: e.b = pc;
            2'd2: e.b = sx({32'h0, ins} >> 20, 12);
            default: e.b = sx({52'h0, ins[31:25], ins[11:7]}, 12);
        endcase
        e.sd = rs2;
        return e;
    endfunction

    task automatic set_entry(input logic [1:0] as, input logic [1:0] bs, input logic [31:0] ins,
                             input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] pc,
                             input logic [63:0] ea, input logic [63:0] eb);
        bus.alu_a_src_i = as;
        bus.alu_b_src_i = bs;
        bus.instr_i     = ins;
        bus.rs1_data_i  = rs1;
        bus.rs2_data_i  = rs2;
        bus.pc_i        = pc;
        pend = '{a: ea, b: eb, sd: rs2};
    endtask

    // One clock: observe handshakes mid-cycle, then advance to just after the edge.
    task automatic step();
        logic in_fire, out_fire;
        exp_t e;
        @(negedge clk_i);
        in_fire  = bus.valid_i && bus.ready_o;
        out_fire = bus.valid_o && bus.ready_i;
        last_in_fire = in_fire && !flush_i;
        if (flush_i) begin
            sb.delete();
        end else begin
            if (out_fire) begin
                compares++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_out: got a=%h with nothing expected", bus.op_a_o);
                end else begin
                    e = sb.pop_front();
                    if ({bus.op_a_o, bus.op_b_o, bus.store_data_o} !== {e.a, e.b, e.sd}) begin
                        errors++;
                        $display("FAIL sb_data: got a=%h b=%h sd=%h expected a=%h b=%h sd=%h",
                                 bus.op_a_o, bus.op_b_o, bus.store_data_o, e.a, e.b, e.sd);
                    end
                end
            end
            if (in_fire) sb.push_back(pend);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        n = 0;
        while ((sb.size() != 0 || bus.valid_o) && n < 50) begin
            step();
            n++;
        end
        compares++;
        if (sb.size() != 0 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, valid_o=%b", sb.size(), bus.valid_o);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        compares += 5;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.valid_o); end
        if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.ready_o); end
        if (bus.op_a_o !== 64'h0) begin errors++; $display("FAIL rst_op_a: got %h want 0", bus.op_a_o); end
        if (bus.op_b_o !== 64'h0) begin errors++; $display("FAIL rst_op_b: got %h want 0", bus.op_b_o); end
        if (bus.store_data_o !== 64'h0) begin errors++; $display("FAIL rst_sd: got %h want 0", bus.store_data_o); end
    endtask

    task automatic test_immediates();
        bus.ready_i = 1'b1;
        set_entry(2'b00, 2'b10, 32'hFFF00093, 64'h1000, 64'h55, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        compares += 3;
        if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b want 1", bus.valid_o); end
        if (bus.op_a_o !== 64'h1000) begin errors++; $display("FAIL addi_op_a: got %h want 1000", bus.op_a_o); end
        if (bus.op_b_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_op_b: got %h want all ones", bus.op_b_o); end
        step();
        // back-to-back entries checked through the scoreboard
        bus.valid_i = 1'b1;
        set_entry(2'b01, 2'b01, 32'h12345097, 64'h0, 64'h11, 64'h8000_0000, 64'h1234_5000, 64'h8000_0000);
        step();
        set_entry(2'b01, 2'b00, 32'h800000B7, 64'h0, 64'h22, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'h22);
        step();
        set_entry(2'b11, 2'b01, 32'hFE000EE3, 64'h0, 64'h33, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100);
        step();
        set_entry(2'b10, 2'b11, 32'h0080006F, 64'h0, 64'h44, 64'h0, 64'h8, 64'h0);
        step();
        set_entry(2'b00, 2'b11, 32'hFE112E23, 64'h7, 64'h66, 64'h0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        drain();
    endtask

    task automatic test_backpressure();
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        set_entry(2'b00, 2'b00, 32'h0, 64'hA, 64'h1A, 64'h0, 64'hA, 64'h1A);
        step();
        set_entry(2'b00, 2'b00, 32'h0, 64'hB, 64'h1B, 64'h0, 64'hB, 64'h1B);
        step();
        set_entry(2'b00, 2'b00, 32'h0, 64'hC, 64'h1C, 64'h0, 64'hC, 64'h1C);
        step();
        compares += 3;
        if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", bus.ready_o); end
        if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", bus.valid_o); end
        if (bus.op_a_o !== 64'hA) begin errors++; $display("FAIL bp_hold_a: got %h want a", bus.op_a_o); end
        bus.ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_in_fire) break;
        end
        drain();
    endtask

    task automatic test_flush();
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        set_entry(2'b00, 2'b00, 32'h0, 64'hD, 64'h1D, 64'h0, 64'hD, 64'h1D);
        step();
        set_entry(2'b00, 2'b00, 32'h0, 64'hE, 64'h1E, 64'h0, 64'hE, 64'h1E);
        step();
        set_entry(2'b00, 2'b00, 32'h0, 64'hF, 64'h1F, 64'h0, 64'hF, 64'h1F);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        bus.valid_i = 1'b0;
        compares += 2;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL flush_full_valid: got %b want 0", bus.valid_o); end
        if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL flush_full_ready: got %b want 1", bus.ready_o); end
        // flush while ready_o=1 must also discard the entry presented with it
        bus.valid_i = 1'b1;
        set_entry(2'b00, 2'b00, 32'h0, 64'h77, 64'h0, 64'h0, 64'h77, 64'h0);
        step();
        set_entry(2'b00, 2'b00, 32'h0, 64'h88, 64'h0, 64'h0, 64'h88, 64'h0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        bus.valid_i = 1'b0;
        compares += 2;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL flush_one_valid: got %b want 0", bus.valid_o); end
        if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL flush_one_ready: got %b want 1", bus.ready_o); end
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        set_entry(2'b00, 2'b01, 32'h0, 64'h99, 64'h5, 64'h40, 64'h99, 64'h40);
        step();
        drain();
    endtask

    task automatic test_async_reset();
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        set_entry(2'b00, 2'b00, 32'h0, 64'h123, 64'h456, 64'h0, 64'h123, 64'h456);
        step();
        set_entry(2'b00, 2'b00, 32'h0, 64'h124, 64'h457, 64'h0, 64'h124, 64'h457);
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        sb.delete();
        test_reset();
        bus.valid_i = 1'b0;
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        set_entry(2'b01, 2'b10, 32'h00001013, 64'h0, 64'h9, 64'h0, 64'h1000, 64'h0);
        step();
        bus.valid_i = 1'b0;
        compares += 2;
        if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL post_rst_latency: got %b want 1", bus.valid_o); end
        if (bus.op_a_o !== 64'h1000) begin errors++; $display("FAIL post_rst_op_a: got %h want 1000", bus.op_a_o); end
        drain();
    endtask

    task automatic test_random();
        logic [1:0]  as, bs;
        logic [31:0] ins;
        logic [63:0] r1, r2, pc;
        exp_t e;
        for (int c = 0; c < 200; c++) begin
            as  = 2'($urandom_range(0, 3));
            bs  = 2'($urandom_range(0, 3));
            ins = $urandom();
            r1  = {$urandom(), $urandom()};
            r2  = {$urandom(), $urandom()};
            pc  = {$urandom(), $urandom()};
            e   = model(as, bs, ins, r1, r2, pc);
            set_entry(as, bs, ins, r1, r2, pc, e.a, e.b);
            bus.valid_i = ($urandom_range(0, 3) != 0);
            bus.ready_i = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        set_entry(2'b00, 2'b00, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        repeat (2) @(posedge clk_i);
        #3;
        test_reset();
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        test_reset();
        test_immediates();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end
endmodule
